// File: rtl/display_pkg.sv
// Shared definitions for the 128x64 LCD framebuffer writers: geometry, the player
// sprite pattern, the framebuffer write beat and the player FSM state type.
package display_pkg;

  localparam int unsigned LCD_COLS    = 128;
  localparam int unsigned LCD_PAGES   = 8;
  localparam logic [2:0]  PLAYER_PAGE = 3'd7;
  localparam int unsigned SPRITE_LEN  = 4;

  // Element [0] is the leftmost sprite column.
  localparam logic [SPRITE_LEN-1:0][7:0] SPRITE_BYTES = {8'h38, 8'h46, 8'h46, 8'h38};

  typedef struct packed {
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] data;
  } fb_wr_t;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw
  } sprite_state_e;

  function automatic logic [7:0] sprite_byte(input logic [1:0] idx);
    return SPRITE_BYTES[idx];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    // Any cycle where the input agrees with the level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/player_sprite_ctrl.sv
// Player sprite controller: debounced left/right moves on tick, erase/draw of the sprite on
// page 7 via a valid/ready framebuffer port, sticky lane collision. Define PLAYER_WRAP_EN to
// wrap the column at the screen edges instead of saturating.
module player_sprite_ctrl
  import display_pkg::*;
#(
  parameter int unsigned COLS            = 128,
  parameter int unsigned SPRITE_W        = 4,
  parameter int unsigned START_COL       = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     left,
  input  logic                     right,
  input  logic                     tick,
  input  logic [COLS-1:0]          lane_row,
  output logic                     fb_valid,
  output logic [2:0]               fb_page,
  output logic [$clog2(COLS)-1:0]  fb_col,
  output logic [7:0]               fb_data,
  input  logic                     fb_ready,
  output logic [$clog2(COLS)-1:0]  player_col,
  output logic                     hit
);

  localparam int unsigned     ColW     = $clog2(COLS);
  localparam int unsigned     BeatW    = $clog2(SPRITE_W);
  localparam logic [ColW-1:0]  MaxCol   = ColW'(COLS - SPRITE_W);
  localparam logic [ColW-1:0]  StartCol = ColW'(START_COL);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(SPRITE_W - 1);

`ifdef PLAYER_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  logic left_db, right_db;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (left),
    .level(left_db)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (right),
    .level(right_db)
  );

  sprite_state_e   state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [ColW-1:0]  player_col_q, player_col_d;
  logic [ColW-1:0]  old_col_q, old_col_d;
  logic             hit_q, hit_d;

  logic            move_l, move_r;
  logic [ColW-1:0] new_col;
  logic            lane_hit;
  fb_wr_t          wr;

  always_comb begin
    move_l = left_db & ~right_db;
    move_r = right_db & ~left_db;

    new_col = player_col_q;
    if (move_r) begin
      if (player_col_q == MaxCol) new_col = WrapEn ? '0 : MaxCol;
      else                        new_col = player_col_q + 1'b1;
    end else if (move_l) begin
      if (player_col_q == '0) new_col = WrapEn ? MaxCol : '0;
      else                    new_col = player_col_q - 1'b1;
    end

    lane_hit = 1'b0;
    for (int i = 0; i < SPRITE_W; i++) begin
      lane_hit = lane_hit | lane_row[new_col + ColW'(i)];
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    player_col_d = player_col_q;
    old_col_d    = old_col_q;
    hit_d        = hit_q;
    wr.page      = PLAYER_PAGE;
    wr.col       = player_col_q + ColW'(beat_q);
    wr.data      = sprite_byte(beat_q);

    unique case (state_q)
      StIdle: begin
        // A move that would not change the column (saturated edge) produces no writes.
        if (tick && (move_l ^ move_r) && !hit_q && (new_col != player_col_q)) begin
          old_col_d    = player_col_q;
          player_col_d = new_col;
          hit_d        = lane_hit;
          beat_d       = '0;
          state_d      = StErase;
        end
      end
      StErase: begin
        wr.col  = old_col_q + ColW'(beat_q);
        wr.data = 8'h00;
        if (fb_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StDraw;
          end
        end
      end
      StDraw: begin
        if (fb_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset lands in StDraw so the sprite is painted as soon as reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StDraw;
      beat_q       <= '0;
      player_col_q <= StartCol;
      old_col_q    <= StartCol;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      player_col_q <= player_col_d;
      old_col_q    <= old_col_d;
      hit_q        <= hit_d;
    end
  end

  assign fb_valid   = (state_q != StIdle) && !rst;
  assign fb_page    = wr.page;
  assign fb_col     = wr.col;
  assign fb_data    = wr.data;
  assign player_col = player_col_q;
  assign hit        = hit_q;

endmodule

// File: doc/player_sprite_ctrl.md
# player_sprite_ctrl

Upstream stage of the 128x64 two-controller graphic LCD driver. Owns the player ("sheep") sprite on page 7: it debounces the left/right buttons, moves the sprite one column per move tick, and checks the new position against the hazard-lane occupancy bitmap. It pushes erase/draw byte writes into the display framebuffer through a valid/ready write port.

## Interface
Parameters:
- COLS, 128, display width in columns
- SPRITE_W, 4, sprite width in columns (fixed pattern length)
- START_COL, 26, sprite column after reset
- DEBOUNCE_CYCLES, 65536, consecutive stable clk cycles required to accept a button level change

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- left  in  1  raw left button, asynchronous to clk
- right  in  1  raw right button, asynchronous to clk
- tick  in  1  one-cycle move-rate strobe
- lane_row  in  128  occupancy of the hazard lane; bit c=1 means column c is occupied
- fb_valid  out  1  framebuffer write request
- fb_page  out  3  write page (always 7)
- fb_col  out  7  write column
- fb_data  out  8  write byte
- fb_ready  in  1  framebuffer accepts the write
- player_col  out  7  current leftmost sprite column
- hit  out  1  sticky collision flag

## Operation
- Each button passes through a 2-flop synchronizer and then a debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- FSM states: IDLE, ERASE, DRAW.
- Reset state: DRAW at START_COL, so the sprite is painted without a prior erase.
- IDLE, on tick:
  - If exactly one debounced button is pressed and hit=0, compute new_col = player_col ∓ 1.
  - Left and right pressed together: no move.
  - Neither pressed: no move.
  - If new_col equals player_col (boundary), stay in IDLE.
  - Otherwise latch old_col, set player_col=new_col and go to ERASE.
- ERASE: write 0x00 to old_col..old_col+3 (4 beats), then go to DRAW.
- DRAW: write 0x38, 0x46, 0x46, 0x38 to player_col..+3 (4 beats), then go to IDLE.
- Collision check at the move decision:
  - If any of lane_row[new_col..new_col+3] is set, hit is set in the same cycle that player_col updates.
  - The move still completes.
  - Once hit=1, all further moves are ignored until rst.
- A tick that arrives outside IDLE is dropped, not queued.
- Column arithmetic is 7-bit. The legal range is 0..COLS-SPRITE_W (0..124).

## Timing
- Reset values:
  - fb_valid=0, fb_page=7, fb_col=START_COL, fb_data=0x38.
  - player_col=START_COL, hit=0, debounced levels=0.
  - The first draw beat is presented in the first cycle after rst deasserts.
- Handshake:
  - A beat transfers on a posedge with fb_valid && fb_ready.
  - While fb_valid=1 and fb_ready=0, fb_page, fb_col and fb_data hold stable.
  - After a transfer the next beat is presented in the following cycle, so the throughput is 1 beat/cycle.
- Latency:
  - tick in IDLE → fb_valid=1 with the first erase beat in the next cycle.
  - A full move takes 8 beats. With fb_ready held high, the FSM is back in IDLE 9 cycles after the tick.
- Button to debounced level: 2 + DEBOUNCE_CYCLES cycles.
- If rst asserts mid-sequence, the sequence aborts immediately and the block restarts with the reset DRAW. Partial writes already made are not undone.

## Configuration
- PLAYER_WRAP_EN defined:
  - Right from 124 goes to 0; left from 0 goes to 124.
  - The erase/draw sequence runs as a normal move.
- Not defined: the column saturates at 0 and 124, and a move at a boundary produces no writes.

## Structure
- Shared package display_pkg holds:
  - LCD_COLS=128, LCD_PAGES=8, PLAYER_PAGE=3'd7.
  - The sprite byte array {8'h38, 8'h46, 8'h46, 8'h38}.
  - fb_wr_t, a struct of page/col/data, reused by every framebuffer writer.
- Sub-module button_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES) is instantiated twice.

## Test plan
- Release rst with fb_ready=1 → 4 beats at page 7, columns 26..29, data 38, 46, 46, 38; player_col=26.
- Hold right debounced, pulse tick → erase beats at columns 26..29 (data 00), then draw beats at 27..30; player_col=27, hit=0.
- Stall fb_ready=0 for 5 cycles mid-erase → fb_col and fb_data stay stable; the sequence resumes with no lost or duplicated beat.
- Set lane_row bit 31 and move right from 27 → hit=1 when player_col=28; later ticks produce no writes.
- Left at column 0 → without PLAYER_WRAP_EN, no writes; with PLAYER_WRAP_EN, player_col=124, erase 0..3, draw 124..127.
- Toggle left every 100 cycles with DEBOUNCE_CYCLES=1000, then hold → no move until stable for 1000 cycles; ticks during ERASE/DRAW are ignored.
